// File: rtl/sort_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sort_feeder: stream front end that loads, kicks and drains an 8x8 sorter.  |
// | Optional SORT_FEEDER_DESC_EN reverses readout order (requires PAD=8'hFF).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sort_feeder #(
  parameter int          LEN     = 8,
  parameter logic [7:0]  PAD     = 8'hFF,
  parameter int          TIMEOUT = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy,
  output logic       err,
  output logic       s_start,
  output logic       s_wr,
  output logic [2:0] s_addr,
  output logic [7:0] s_datain,
  input  logic [7:0] s_dataout,
  input  logic       s_ready
);

  typedef enum logic [3:0] {
    S_SYNC    = 4'd0,
    S_LOAD    = 4'd1,
    S_KICK    = 4'd2,
    S_WAIT_LO = 4'd3,
    S_WAIT_HI = 4'd4,
    S_RD      = 4'd5,
    S_CAP     = 4'd6,
    S_HOLD    = 4'd7,
    S_ERR     = 4'd8
  } state_t;

  localparam logic [3:0] c_len      = 4'(LEN);
  localparam int         c_tw       = $clog2(TIMEOUT + 1);
  localparam logic [c_tw-1:0] c_tmr_last = c_tw'(TIMEOUT - 1);

`ifdef SORT_FEEDER_DESC_EN
  localparam logic [2:0] c_k_first = 3'(LEN - 1);
  localparam logic [2:0] c_k_last  = 3'd0;
`else
  localparam logic [2:0] c_k_first = 3'd0;
  localparam logic [2:0] c_k_last  = 3'(LEN - 1);
`endif

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic [c_tw-1:0] tmr_q;
  logic [2:0]      k_q;
  logic            err_q;
  logic            out_valid_q;
  logic [7:0]      out_data_q;

  logic            w_load;
  logic            w_take;
  logic            w_pad;
  logic            w_wr;
  logic [2:0]      w_k_next;

  assign w_load = (state_q == S_LOAD);
  assign w_take = w_load && (cnt_q < c_len);
  assign w_pad  = w_load && (cnt_q >= c_len);
  // Payload writes need the live input byte, so the write strobe is decoded combinationally.
  assign w_wr   = (w_take && in_valid) || w_pad;

`ifdef SORT_FEEDER_DESC_EN
  assign w_k_next = k_q - 3'd1;
`else
  assign w_k_next = k_q + 3'd1;
`endif

  assign in_ready  = w_take;
  assign s_wr      = w_wr;
  assign s_start   = (state_q == S_KICK);
  assign s_addr    = w_wr ? cnt_q[2:0] : ((state_q == S_RD) ? k_q : 3'd0);
  assign s_datain  = !w_wr ? 8'd0 : (w_take ? in_data : PAD);
  assign busy      = !((state_q == S_SYNC) || (w_load && (cnt_q == 4'd0)));
  assign err       = err_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_SYNC;
      cnt_q       <= 4'd0;
      tmr_q       <= '0;
      k_q         <= 3'd0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
    end else begin
      case (state_q)
        S_SYNC: begin
          cnt_q <= 4'd0;
          if (s_ready) state_q <= S_LOAD;
        end
        S_LOAD: begin
          if (w_wr) begin
            if (cnt_q == 4'd7) begin
              cnt_q   <= 4'd0;
              state_q <= S_KICK;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end
        S_KICK: state_q <= S_WAIT_LO;
        S_WAIT_LO: begin
          if (!s_ready) begin
            tmr_q   <= '0;
            state_q <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          if (s_ready) begin
            k_q     <= c_k_first;
            state_q <= S_RD;
          end else if (tmr_q == c_tmr_last) begin
            err_q   <= 1'b1;
            state_q <= S_ERR;
          end else begin
            tmr_q <= tmr_q + c_tw'(1);
          end
        end
        S_RD: state_q <= S_CAP;
        // Sorter read data for the address presented in RD is valid here.
        S_CAP: begin
          out_data_q  <= s_dataout;
          out_valid_q <= 1'b1;
          state_q     <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (k_q == c_k_last) begin
              cnt_q   <= 4'd0;
              state_q <= S_LOAD;
            end else begin
              k_q     <= w_k_next;
              state_q <= S_RD;
            end
          end
        end
        S_ERR: begin
          err_q       <= 1'b1;
          out_valid_q <= 1'b0;
        end
        default: state_q <= S_SYNC;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sort_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sort_feeder: directed bench with a behavioural sorter per DUT instance. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_sort_feeder;

  typedef logic [7:0] byte8_t [8];
  typedef struct {
    int     unit;
    byte8_t din;
    byte8_t dout;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       in_valid  [2];
  logic [7:0] in_data   [2];
  logic       in_ready  [2];
  logic       out_valid [2];
  logic [7:0] out_data  [2];
  logic       out_ready [2];
  logic       busy      [2];
  logic       err       [2];
  logic       s_start   [2];
  logic       s_wr      [2];
  logic [2:0] s_addr    [2];
  logic [7:0] s_datain  [2];
  logic [7:0] s_dataout [2];
  logic       s_ready   [2];
  logic       stuck     [2];

  byte8_t     mem       [2];
  int         sdly      [2];
  int         start_cnt [2];
  int         wr_pad    [2];
  logic [7:0] wr_seen   [2];

  int total = 0;
  int bad   = 0;

  sort_feeder #(.LEN(8)) u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_data(in_data[0]), .in_ready(in_ready[0]),
    .out_valid(out_valid[0]), .out_data(out_data[0]), .out_ready(out_ready[0]),
    .busy(busy[0]), .err(err[0]),
    .s_start(s_start[0]), .s_wr(s_wr[0]), .s_addr(s_addr[0]), .s_datain(s_datain[0]),
    .s_dataout(s_dataout[0]), .s_ready(s_ready[0])
  );

  sort_feeder #(.LEN(4)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_data(in_data[1]), .in_ready(in_ready[1]),
    .out_valid(out_valid[1]), .out_data(out_data[1]), .out_ready(out_ready[1]),
    .busy(busy[1]), .err(err[1]),
    .s_start(s_start[1]), .s_wr(s_wr[1]), .s_addr(s_addr[1]), .s_datain(s_datain[1]),
    .s_dataout(s_dataout[1]), .s_ready(s_ready[1])
  );

  always #5 clk = ~clk;

  function automatic byte8_t sort8(input byte8_t a);
    byte8_t r;
    logic [7:0] t;
    r = a;
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 7 - i; j++)
        if (r[j] > r[j+1]) begin
          t = r[j]; r[j] = r[j+1]; r[j+1] = t;
        end
    return r;
  endfunction

  // Behavioural sorter: sync write/read, drops ready the cycle after start, sorts after a delay.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        s_ready[u]   <= 1'b1;
        sdly[u]      <= 0;
        start_cnt[u] <= 0;
        wr_pad[u]    <= 0;
        wr_seen[u]   <= 8'd0;
      end else begin
        if (s_wr[u]) begin
          mem[u][s_addr[u]]     <= s_datain[u];
          wr_seen[u][s_addr[u]] <= 1'b1;
          if (int'(s_addr[u]) >= ((u == 0) ? 8 : 4) && s_datain[u] == 8'hFF)
            wr_pad[u] <= wr_pad[u] + 1;
        end
        if (s_start[u]) begin
          s_ready[u]   <= 1'b0;
          sdly[u]      <= 4;
          start_cnt[u] <= start_cnt[u] + 1;
        end else if (!s_ready[u] && !stuck[u]) begin
          if (sdly[u] == 0) begin
            mem[u]     <= sort8(mem[u]);
            s_ready[u] <= 1'b1;
          end else begin
            sdly[u] <= sdly[u] - 1;
          end
        end
      end
      s_dataout[u] <= mem[u][s_addr[u]];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic byte8_t order_of(input byte8_t a, input int n);
    byte8_t r;
    int desc;
    desc = 0;
`ifdef SORT_FEEDER_DESC_EN
    desc = 1;
`endif
    for (int i = 0; i < 8; i++)
      r[i] = (desc != 0 && i < n) ? a[n-1-i] : a[i];
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input int u, input byte8_t d, input int n);
    int guard;
    for (int i = 0; i < n; i++) begin
      in_valid[u] = 1'b1;
      in_data[u]  = d[i];
      guard = 0;
      while (!in_ready[u] && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (!in_ready[u]) begin
        chk("send_timeout", 32'd0, 32'd1);
        break;
      end
      @(negedge clk);
    end
    in_valid[u] = 1'b0;
    in_data[u]  = 8'd0;
  endtask

  task automatic recv(input int u, input byte8_t e, input int n, input string nm, output int t [8]);
    int guard;
    int cyc;
    cyc = 0;
    for (int i = 0; i < 8; i++) t[i] = 0;
    for (int i = 0; i < n; i++) begin
      guard = 0;
      while (!out_valid[u] && guard < 60) begin
        @(negedge clk);
        guard++;
        cyc++;
      end
      if (!out_valid[u]) begin
        chk($sformatf("%s_timeout[%0d]", nm, i), 32'd0, 32'd1);
        return;
      end
      t[i] = cyc;
      chk($sformatf("%s_data[%0d]", nm, i), 32'(out_data[u]), 32'(e[i]));
      @(negedge clk);
      cyc++;
      chk($sformatf("%s_vdrop[%0d]", nm, i), 32'(out_valid[u]), 32'd0);
    end
  endtask

  vec_t   vecs [5];
  byte8_t ex;
  byte8_t rest;
  byte8_t ones;
  int     tt [8];
  int     u;
  int     n;
  int     guard;

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      stuck[i] = 1'b0; in_valid[i] = 1'b0; in_data[i] = 8'd0; out_ready[i] = 1'b0;
    end
    vecs[0] = '{unit: 0, din: '{8'd5, 8'd3, 8'd7, 8'd1, 8'd0, 8'd6, 8'd2, 8'd4},
                dout: '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7}};
    vecs[1] = '{unit: 1, din: '{8'd9, 8'd2, 8'd8, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0},
                dout: '{8'd2, 8'd2, 8'd8, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[2] = '{unit: 0, din: '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7},
                dout: '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7}};
    vecs[3] = '{unit: 0, din: '{8'hFF, 8'h00, 8'hFF, 8'h80, 8'h7F, 8'h01, 8'hFF, 8'h10},
                dout: '{8'h00, 8'h01, 8'h10, 8'h7F, 8'h80, 8'hFF, 8'hFF, 8'hFF}};
    vecs[4] = '{unit: 1, din: '{8'hFF, 8'hFF, 8'h00, 8'hFF, 8'd0, 8'd0, 8'd0, 8'd0},
                dout: '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'd0, 8'd0, 8'd0, 8'd0}};
    for (int i = 0; i < 8; i++) ones[i] = 8'd1;

    repeat (3) @(negedge clk);
    chk("rst_in_ready",  32'(in_ready[0]),  32'd0);
    chk("rst_out_valid", 32'(out_valid[0]), 32'd0);
    chk("rst_out_data",  32'(out_data[0]),  32'd0);
    chk("rst_err",       32'(err[0]),       32'd0);
    chk("rst_busy",      32'(busy[0]),      32'd0);
    chk("rst_s_start",   32'(s_start[0]),   32'd0);
    chk("rst_s_wr",      32'(s_wr[0]),      32'd0);
    chk("rst_s_addr",    32'(s_addr[0]),    32'd0);
    chk("rst_s_datain",  32'(s_datain[0]),  32'd0);
    chk("rst_err1",      32'(err[1]),       32'd0);
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      do_reset();
      u  = vecs[v].unit;
      n  = (u == 0) ? 8 : 4;
      ex = order_of(vecs[v].dout, n);
      out_ready[u] = 1'b1;
      send(u, vecs[v].din, n);
      chk($sformatf("v%0d_busy_mid", v), 32'(busy[u]), 32'd1);
      recv(u, ex, n, $sformatf("v%0d", v), tt);
      for (int i = 1; i < n; i++)
        chk($sformatf("v%0d_gap[%0d]", v, i), 32'(tt[i] - tt[i-1]), 32'd3);
      chk($sformatf("v%0d_busy_end", v), 32'(busy[u]), 32'd0);
      chk($sformatf("v%0d_starts", v), 32'(start_cnt[u]), 32'd1);
      chk($sformatf("v%0d_wr_seen", v), 32'(wr_seen[u]), 32'hFF);
      chk($sformatf("v%0d_pad_wr", v), 32'(wr_pad[u]), (u == 0) ? 32'd0 : 32'd4);
      out_ready[u] = 1'b0;
    end

    // Backpressure on the third byte, with an ignored input byte offered meanwhile.
    do_reset();
    ex = order_of(vecs[0].dout, 8);
    out_ready[0] = 1'b1;
    send(0, vecs[0].din, 8);
    recv(0, ex, 2, "bp_head", tt);
    out_ready[0] = 1'b0;
    guard = 0;
    while (!out_valid[0] && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    chk("bp_valid_up", 32'(out_valid[0]), 32'd1);
    chk("bp_data", 32'(out_data[0]), 32'(ex[2]));
    in_valid[0] = 1'b1;
    in_data[0]  = 8'hAA;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_v[%0d]", i), 32'(out_valid[0]), 32'd1);
      chk($sformatf("bp_hold_d[%0d]", i), 32'(out_data[0]), 32'(ex[2]));
      chk($sformatf("bp_addr[%0d]", i), 32'(s_addr[0]), 32'd0);
      chk($sformatf("bp_wr[%0d]", i), 32'(s_wr[0]), 32'd0);
      chk($sformatf("bp_inrdy[%0d]", i), 32'(in_ready[0]), 32'd0);
    end
    in_valid[0]  = 1'b0;
    in_data[0]   = 8'd0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    chk("bp_release", 32'(out_valid[0]), 32'd0);
    for (int i = 0; i < 8; i++) rest[i] = (i < 5) ? ex[i+3] : 8'd0;
    recv(0, rest, 5, "bp_tail", tt);
    chk("bp_busy_end", 32'(busy[0]), 32'd0);
    out_ready[0] = 1'b0;

    // Sorter never raises ready again: err must assert TIMEOUT cycles into WAIT_HI.
    do_reset();
    stuck[1] = 1'b1;
    out_ready[1] = 1'b1;
    send(1, vecs[1].din, 4);
    guard = 0;
    while (!s_start[1] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("to_kick", 32'(s_start[1]), 32'd1);
    repeat (201) @(negedge clk);
    chk("to_err_early", 32'(err[1]), 32'd0);
    @(negedge clk);
    chk("to_err_set", 32'(err[1]), 32'd1);
    chk("to_inrdy", 32'(in_ready[1]), 32'd0);
    chk("to_outv", 32'(out_valid[1]), 32'd0);
    in_valid[1] = 1'b1;
    repeat (5) @(negedge clk);
    chk("to_err_hold", 32'(err[1]), 32'd1);
    chk("to_inrdy_hold", 32'(in_ready[1]), 32'd0);
    chk("to_outv_hold", 32'(out_valid[1]), 32'd0);
    chk("to_wr_hold", 32'(s_wr[1]), 32'd0);
    in_valid[1]  = 1'b0;
    stuck[1]     = 1'b0;
    out_ready[1] = 1'b0;
    do_reset();
    chk("to_err_clr", 32'(err[1]), 32'd0);

    // Reset in the middle of readout, then a fresh frame.
    do_reset();
    ex = order_of(vecs[0].dout, 8);
    out_ready[0] = 1'b1;
    send(0, vecs[0].din, 8);
    recv(0, ex, 3, "mr_head", tt);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_rst_inrdy", 32'(in_ready[0]), 32'd0);
    chk("mr_rst_outv", 32'(out_valid[0]), 32'd0);
    chk("mr_rst_addr", 32'(s_addr[0]), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("mr_load_inrdy", 32'(in_ready[0]), 32'd1);
    send(0, ones, 8);
    recv(0, ones, 8, "mr_ones", tt);
    chk("mr_starts", 32'(start_cnt[0]), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
